// File: rtl/llm_int8_block_quantizer.sv
// llm_int8_block_quantizer
//   Quantizes one block of N = IN_SIZE*IN_PARALLELISM signed elements to
//   OUT_WIDTH-bit signed codes. A single power-of-two scale is used for the
//   whole block. The block's absolute maximum (max_num) selects a right-shift
//   exponent so that the largest element fits in OUT_WIDTH bits. Each element
//   is then rounded half-up and saturated symmetrically, LANES elements per
//   cycle.
//
// Ports
//   clk            : single clock
//   rst            : asynchronous active-low reset
//   data_in        : N x IN_WIDTH signed block, element i at [i*IN_WIDTH +: IN_WIDTH]
//   max_num        : unsigned absolute maximum of the block (arrives with data_in)
//   data_in_valid  : block and max_num valid
//   data_in_ready  : block accepted when valid & ready (high only when idle)
//   data_out       : N x OUT_WIDTH signed quantized block, same element order
//   data_out_shift : right-shift exponent applied (scale = 2^shift)
//   data_out_valid : output block valid
//   data_out_ready : downstream accepts the output block
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an input block; data_in_ready high
// SHIFT | derive the shift exponent from the captured max_num
// QUANT | quantize LANES elements per cycle into the output register
// OUT   | present data_out until the downstream handshake
module llm_int8_block_quantizer #(
    parameter int IN_WIDTH       = 16,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 1,
    parameter int OUT_WIDTH      = 8,
    parameter int MAX_NUM_WIDTH  = IN_WIDTH,
    parameter int LANES          = 1,
    localparam int N             = IN_SIZE * IN_PARALLELISM,
    localparam int SW            = $clog2(MAX_NUM_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N*IN_WIDTH-1:0]      data_in,
    input  logic [MAX_NUM_WIDTH-1:0]   max_num,
    input  logic                       data_in_valid,
    output logic                       data_in_ready,
    output logic [N*OUT_WIDTH-1:0]     data_out,
    output logic [SW-1:0]              data_out_shift,
    output logic                       data_out_valid,
    input  logic                       data_out_ready
);

    localparam int GROUPS = N / LANES;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(GROUPS - 1);

    // Symmetric saturation bounds; the most negative code is never produced.
    localparam int QMAX_I = (1 << (OUT_WIDTH - 1)) - 1;
    localparam logic signed [IN_WIDTH:0] QMAX = (IN_WIDTH + 1)'(QMAX_I);
    localparam logic signed [IN_WIDTH:0] QMIN = -QMAX;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_QUANT,
        ST_OUT
    } state_e;

    state_e                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [N*IN_WIDTH-1:0]      data_q, data_d;
    logic [MAX_NUM_WIDTH-1:0]   max_q, max_d;
    logic [SW-1:0]              shift_q, shift_d;
    logic [N*OUT_WIDTH-1:0]     dout_q, dout_d;

    logic [SW-1:0]              lead;
    logic [SW-1:0]              shift_calc;

    // Round half-up and shift at IN_WIDTH+1 bits so adding the rounding
    // constant to the largest positive input cannot wrap.
    function automatic logic [OUT_WIDTH-1:0] quant(
        input logic signed [IN_WIDTH-1:0] x,
        input logic        [SW-1:0]       s
    );
        logic signed [IN_WIDTH:0] xe;
        logic signed [IN_WIDTH:0] rnd;
        logic signed [IN_WIDTH:0] q;
        xe  = {x[IN_WIDTH-1], x};
        rnd = '0;
        q   = xe;
        if (s != '0) begin
            rnd = (IN_WIDTH + 1)'(1) << (s - SW'(1));
            q   = (xe + rnd) >>> s;
        end
        if (q > QMAX) begin
            quant = QMAX[OUT_WIDTH-1:0];
        end else if (q < QMIN) begin
            quant = QMIN[OUT_WIDTH-1:0];
        end else begin
            quant = q[OUT_WIDTH-1:0];
        end
    endfunction

    // Index of the leading one of the captured max_num (0 when max_num is 0).
    always_comb begin
        lead = '0;
        for (int i = 0; i < MAX_NUM_WIDTH; i++) begin
            if (max_q[i]) begin
                lead = SW'(i);
            end
        end
    end

    // Keep OUT_WIDTH-1 magnitude bits: anything above bit OUT_WIDTH-2 is shifted out.
    always_comb begin
        shift_calc = '0;
        if (int'(lead) > OUT_WIDTH - 2) begin
            shift_calc = SW'(int'(lead) - (OUT_WIDTH - 2));
        end
    end

    always_comb begin
        int idx;
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        max_d   = max_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        idx     = 0;
        case (state_q)
            ST_IDLE: begin
                if (data_in_valid) begin
                    data_d  = data_in;
                    max_d   = max_num;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = shift_calc;
                cnt_d   = '0;
                state_d = ST_QUANT;
            end
            ST_QUANT: begin
                for (int l = 0; l < LANES; l++) begin
                    idx = int'(cnt_q) * LANES + l;
                    dout_d[idx*OUT_WIDTH +: OUT_WIDTH] =
                        quant(data_q[idx*IN_WIDTH +: IN_WIDTH], shift_q);
                end
                if (cnt_q == LAST_GRP) begin
                    cnt_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_OUT: begin
                if (data_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            max_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            max_q   <= max_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
        end
    end

    assign data_in_ready  = (state_q == ST_IDLE);
    assign data_out_valid = (state_q == ST_OUT);
    assign data_out       = dout_q;
    assign data_out_shift = shift_q;

endmodule

// File: tb/tb_llm_int8_block_quantizer.sv
// Testbench for llm_int8_block_quantizer: directed vectors with literal
// expectations, a stall/backpressure case, reset in mid-block, a LANES=2
// latency case, and randomized blocks checked against a behavioural model.
module tb_llm_int8_block_quantizer;

    localparam int IW  = 16;
    localparam int OW  = 8;
    localparam int NN  = 4;
    localparam int SWW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NN*IW-1:0]  din, din2;
    logic [15:0]       mx, mx2;
    logic              iv, iv2, ir, ir2;
    logic [NN*OW-1:0]  dout, dout2;
    logic [SWW-1:0]    dsh, dsh2;
    logic              ov, ov2, ordy, ordy2;

    llm_int8_block_quantizer #(.LANES(1)) dut (
        .clk(clk), .rst(rst),
        .data_in(din), .max_num(mx), .data_in_valid(iv), .data_in_ready(ir),
        .data_out(dout), .data_out_shift(dsh), .data_out_valid(ov),
        .data_out_ready(ordy)
    );

    llm_int8_block_quantizer #(.LANES(2)) dut2 (
        .clk(clk), .rst(rst),
        .data_in(din2), .max_num(mx2), .data_in_valid(iv2), .data_in_ready(ir2),
        .data_out(dout2), .data_out_shift(dsh2), .data_out_valid(ov2),
        .data_out_ready(ordy2)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int model_shift(input int m);
        int lead;
        lead = -1;
        for (int i = 0; i < 16; i++) if (m[i]) lead = i;
        return (lead > OW - 2) ? lead - (OW - 2) : 0;
    endfunction

    function automatic int model_q(input int x, input int s);
        int q;
        if (s == 0) q = x;
        else        q = (x + (1 << (s - 1))) >>> s;
        if (q > 127)  q = 127;
        if (q < -127) q = -127;
        return q;
    endfunction

    function automatic logic [NN*OW-1:0] model_block(input logic [NN*IW-1:0] d, input int m);
        logic [NN*OW-1:0] r;
        int s;
        s = model_shift(m);
        r = '0;
        for (int i = 0; i < NN; i++)
            r[i*OW +: OW] = 8'(model_q(int'($signed(d[i*IW +: IW])), s));
        return r;
    endfunction

    function automatic logic [63:0] pack16(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [31:0] pack8(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // ---------------- output ready generator ----------------
    int rdy_mode = 1;  // 0 random, 1 high, 2 low
    always begin
        if (rdy_mode == 1)      ordy = 1'b1;
        else if (rdy_mode == 2) ordy = 1'b0;
        else                    ordy = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
    end

    // ---------------- compare process ----------------
    typedef struct {
        logic [NN*OW-1:0] d;
        logic [SWW-1:0]   s;
        int               acc;
    } exp_t;
    exp_t expq[$];
    exp_t mon_e;
    bit   shown = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            expq.delete();
            shown = 1'b0;
        end else begin
            if (ov) begin
                check("ready_low_in_out", 64'(ir), 64'(0));
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=1 required=0");
                end else begin
                    if (!shown) begin
                        check("latency", 64'(cyc - expq[0].acc), 64'(NN + 2));
                        shown = 1'b1;
                    end
                    check("data_out", 64'(dout), 64'(expq[0].d));
                    check("data_out_shift", 64'(dsh), 64'(expq[0].s));
                    if (ordy) begin
                        void'(expq.pop_front());
                        shown = 1'b0;
                    end
                end
            end
            if (iv && ir) begin
                mon_e.d   = model_block(din, int'(mx));
                mon_e.s   = 4'(model_shift(int'(mx)));
                mon_e.acc = cyc;
                expq.push_back(mon_e);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic present(input logic [63:0] d, input logic [15:0] m);
        @(posedge clk);
        #1;
        din = d;
        mx  = m;
        iv  = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (ir) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 64'(ok), 64'(1));
        @(posedge clk);
        #1;
        iv = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ov) begin
                ok = 1'b1;
                break;
            end
        end
        check("valid_timeout", 64'(ok), 64'(1));
    endtask

    task automatic directed(input string name, input logic [63:0] d, input logic [15:0] m,
                            input logic [31:0] exp_d, input int exp_s);
        present(d, m);
        wait_accept();
        wait_valid();
        check({name, "_data"}, 64'(dout), 64'(exp_d));
        check({name, "_shift"}, 64'(dsh), 64'(exp_s));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap;
        logic [63:0] rd;
        logic [15:0] rm;
        int          acc2, k, lim, x;
        bit          ok;

        rst = 1'b0; iv = 1'b0; iv2 = 1'b0; din = '0; mx = '0;
        din2 = '0; mx2 = '0; ordy2 = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(ov), 64'(0));
        check("reset_dout", 64'(dout), 64'(0));
        check("reset_shift", 64'(dsh), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(ir), 64'(1));
        check("ready_after_reset_l2", 64'(ir2), 64'(1));

        // pin the model against hand-computed values
        check("model_shift_1000", 64'(model_shift(1000)), 64'(3));
        check("model_shift_32768", 64'(model_shift(32768)), 64'(9));
        check("model_q_1000", 64'(model_q(1000, 3)), 64'(125));
        check("model_q_m1000", 64'(model_q(-1000, 3)), 64'(-125));
        check("model_q_m1100", 64'(model_q(-1100, 3)), 64'(-127));
        check("model_q_m32768", 64'(model_q(-32768, 9)), 64'(-64));

        directed("req018", pack16(1000, -1000, 4, -4), 16'd1000, pack8(125, -125, 1, 0), 3);
        directed("req019a", pack16(100, -100, 0, 7), 16'd100, pack8(100, -100, 0, 7), 0);
        directed("req019b", pack16(0, 0, 0, 0), 16'd0, pack8(0, 0, 0, 0), 0);
        directed("req020", pack16(1020, -1100, 1019, 3), 16'd1000, pack8(127, -127, 127, 0), 3);
        directed("req021", pack16(-32768, 32767, 256, 255), 16'h8000, pack8(-64, 64, 1, 0), 9);

        // backpressure: output held, new block presented, must not be taken
        rdy_mode = 2;
        present(pack16(1000, -1000, 4, -4), 16'd1000);
        wait_accept();
        wait_valid();
        snap = dout;
        @(posedge clk);
        #1;
        din = pack16(-500, 250, 37, -8);
        mx  = 16'd500;
        iv  = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            check("stall_ready", 64'(ir), 64'(0));
            check("stall_valid", 64'(ov), 64'(1));
            check("stall_dout", 64'(dout), 64'(snap));
        end
        rdy_mode = 1;
        wait_accept();
        wait_valid();
        check("after_stall_data", 64'(dout), 64'(pack8(-125, 63, 9, -2)));
        check("after_stall_shift", 64'(dsh), 64'(2));

        // reset during QUANT discards the block
        present(pack16(1000, -1000, 4, -4), 16'd1000);
        wait_accept();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("midrst_valid", 64'(ov), 64'(0));
        check("midrst_dout", 64'(dout), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 64'(ir), 64'(1));
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            check("midrst_no_valid", 64'(ov), 64'(0));
        end
        directed("req023", pack16(1000, -1000, 4, -4), 16'd1000, pack8(125, -125, 1, 0), 3);

        // LANES=2 instance: valid four cycles after the handshake
        @(posedge clk);
        #1;
        din2 = pack16(1000, -1000, 4, -4);
        mx2  = 16'd1000;
        iv2  = 1'b1;
        @(negedge clk);
        check("l2_ready", 64'(ir2), 64'(1));
        acc2 = cyc;
        @(posedge clk);
        #1;
        iv2 = 1'b0;
        ok  = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ov2) begin
                ok = 1'b1;
                break;
            end
        end
        check("l2_valid_timeout", 64'(ok), 64'(1));
        check("l2_latency", 64'(cyc - acc2), 64'(4));
        check("l2_data", 64'(dout2), 64'(pack8(125, -125, 1, 0)));
        check("l2_shift", 64'(dsh2), 64'(3));

        // randomized blocks with random output backpressure
        rdy_mode = 0;
        for (int b = 0; b < 60; b++) begin
            k = $urandom_range(0, 16);
            if (k == 0) rm = 16'd0;
            else rm = 16'((1 << (k - 1)) + $urandom_range(0, (1 << (k - 1)) - 1));
            lim = (int'(rm) > 32767) ? 32767 : int'(rm);
            rd  = '0;
            for (int i = 0; i < NN; i++) begin
                if ($urandom_range(0, 7) == 0) x = int'($signed(16'($urandom)));
                else x = int'($urandom_range(0, 2 * lim)) - lim;
                rd[i*IW +: IW] = 16'(x);
            end
            present(rd, rm);
            wait_accept();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rdy_mode = 1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (expq.size() == 0 && !ov) break;
        end
        check("drain", 64'(expq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/llm_int8_block_quantizer.md
LLM_INT8_BLOCK_QUANTIZER -- requirements
Module: llm_int8_block_quantizer

Interface
REQ-001 Parameters SHALL be:
- IN_WIDTH, default 16, signed input element width.
- IN_SIZE, default 4, columns per block.
- IN_PARALLELISM, default 1, rows per block.
- OUT_WIDTH, default 8, signed quantized width; 2 <= OUT_WIDTH <= IN_WIDTH.
- MAX_NUM_WIDTH, default IN_WIDTH, width of max_num.
- LANES, default 1, elements quantized per cycle; divides N.
- N is IN_SIZE*IN_PARALLELISM. SW is $clog2(MAX_NUM_WIDTH).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-low reset.
- data_in, in, N x IN_WIDTH, signed block.
- max_num, in, MAX_NUM_WIDTH, unsigned absolute maximum of the block, synchronous with data_in.
- data_in_valid, in, 1, block and max_num valid.
- data_in_ready, out, 1, block accepted when valid & ready.
- data_out, out, N x OUT_WIDTH, signed quantized block.
- data_out_shift, out, SW, right-shift exponent applied (scale = 2^shift).
- data_out_valid, out, 1, output valid.
- data_out_ready, in, 1, downstream accepts.

Function
REQ-003 The FSM SHALL have four states: IDLE, SHIFT, QUANT, OUT.
REQ-004 data_in_ready SHALL be 1 only in IDLE; on data_in_valid & data_in_ready, data_in and max_num SHALL be registered and the FSM SHALL go to SHIFT.
REQ-005 SHIFT SHALL take one cycle, computing s = max(0, m - (OUT_WIDTH-2)), where m is the index of the leading one of max_num; s = 0 when max_num == 0. The FSM then goes to QUANT with the lane counter at 0.
REQ-006 QUANT SHALL quantize elements [k*LANES, k*LANES+LANES-1] in cycle k, for k = 0..N/LANES-1. After the last group it SHALL go to OUT.
REQ-007 Per element, with s > 0: q = (x + 2^(s-1)) >>> s, an arithmetic shift computed at IN_WIDTH+1 bits so there is no intermediate overflow. With s == 0: q = x.
REQ-008 q SHALL saturate symmetrically to [-(2^(OUT_WIDTH-1)-1), +(2^(OUT_WIDTH-1)-1)]; the most negative code SHALL never be emitted.
REQ-009 In OUT, data_out_valid SHALL be 1, with data_out and data_out_shift=s stable until data_out_ready. On handshake the FSM SHALL go to IDLE next cycle.
REQ-010 Latency SHALL be: input handshake at cycle 0; data_out_valid rises at cycle N/LANES+2. Minimum block period SHALL be N/LANES+3 cycles.
REQ-011 data_out_valid SHALL be low in IDLE, SHIFT and QUANT. data_out SHALL hold the last quantized block outside OUT.
REQ-012 If max_num is smaller than an actual element's magnitude, the result SHALL saturate per REQ-008 with no error flag.
REQ-013 data_in changes while data_in_ready is low SHALL have no effect.
REQ-014 data_out_ready held low in OUT SHALL stall indefinitely without corrupting data or accepting new input.

Reset
REQ-015 When rst is low, the block SHALL asynchronously enter IDLE with:
- data_out_valid = 0
- data_out_shift = 0
- data_out = all zeros
- lane counter = 0
- captured registers = 0
REQ-016 data_in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-017 Reset mid-block, in any state, SHALL discard the block; no partial output SHALL ever become valid.

Verification
Defaults: IN_WIDTH=16, OUT_WIDTH=8, N=4, LANES=1.
REQ-018 max_num=1000, data_in={1000,-1000,4,-4} -> shift=3, data_out={125,-125,1,0}, valid at cycle 6.
REQ-019 max_num=100, data_in={100,-100,0,7} -> shift=0, data_out={100,-100,0,7}. Also max_num=0 with an all-zero block -> shift=0, outputs 0.
REQ-020 max_num=1000, data_in={1020,-1100,1019,3} -> data_out={127,-127,127,0}, covering rounding overflow and saturation.
REQ-021 max_num=32768, data_in={-32768,32767,256,255} -> shift=9, data_out={-64,64,1,0}.
REQ-022 data_out_ready held low 20 cycles, with data_in_valid high and a new block presented -> data_in_ready stays 0 and data_out stays stable. After ready, the second block is accepted in IDLE and produced correctly.
REQ-023 rst pulsed low during QUANT -> data_out_valid stays 0 and data_in_ready is 1 after release. The next block is quantized correctly. Also repeat REQ-018 with LANES=2 -> valid at cycle 4.
